// File: rtl/vga_timing_gen_pkg.sv
// Shared types, default 640x480@60 timing and helpers for the VGA timing generator.
package vga_timing_gen_pkg;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned n;
        r = 0;
        n = (v > 0) ? v - 1 : 0;
        while (n > 0) begin
            r = r + 1;
            n = n >> 1;
        end
        return r;
    endfunction

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;
    localparam int unsigned DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int unsigned DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int unsigned DEF_XW       = clog2(DEF_H_TOTAL);
    localparam int unsigned DEF_YW       = clog2(DEF_V_TOTAL);
    localparam int unsigned DEF_PIX_W    = 8;

    localparam bit POL_ACTIVE_LOW  = 1'b0;
    localparam bit POL_ACTIVE_HIGH = 1'b1;

    // Active-high timing flags carried through the latency-compensation delay line.
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } sync_t;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Framebuffer/DAC-side bundle of the VGA timing generator.
interface vga_timing_gen_if #(
    parameter int unsigned PIX_W = 8,
    parameter int unsigned XW    = 10,
    parameter int unsigned YW    = 10
);
    logic [PIX_W-1:0] pixelIn;
    logic [PIX_W-1:0] pixelOut;
    logic             Hsync;
    logic             Vsync;
    logic             de;
    logic [XW-1:0]    posX;
    logic [YW-1:0]    posY;
    logic [XW-1:0]    fbX;
    logic [YW-1:0]    fbY;
    logic             rd_en;
    logic             line_start;
    logic             frame_start;

    modport master (
        input  pixelIn,
        output pixelOut, Hsync, Vsync, de, posX, posY, fbX, fbY,
        output rd_en, line_start, frame_start
    );

    modport slave (
        output pixelIn,
        input  pixelOut, Hsync, Vsync, de, posX, posY, fbX, fbY,
        input  rd_en, line_start, frame_start
    );
endinterface

// File: rtl/vga_timing_gen_delay_line.sv
// En-gated shift register of DEPTH stages with asynchronous active-low clear.
module vga_timing_gen_delay_line #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    if (DEPTH == 0) begin : g_bypass
        assign dout = din;
    end else begin : g_shift
        logic [DEPTH*WIDTH-1:0] sr;
        logic [DEPTH*WIDTH-1:0] srNext;

        if (DEPTH == 1) begin : g_single
            assign srNext = din;
        end else begin : g_multi
            assign srNext = {sr[(DEPTH-1)*WIDTH-1:0], din};
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                sr <= '0;
            end else if (en) begin
                sr <= srNext;
            end
        end

        assign dout = sr[DEPTH*WIDTH-1 -: WIDTH];
    end
endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster counters, sync/DE generation and framebuffer-latency-aligned pixel output.
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
    parameter int unsigned H_FP        = DEF_H_FP,
    parameter int unsigned H_SYNC      = DEF_H_SYNC,
    parameter int unsigned H_BP        = DEF_H_BP,
    parameter int unsigned V_ACTIVE    = DEF_V_ACTIVE,
    parameter int unsigned V_FP        = DEF_V_FP,
    parameter int unsigned V_SYNC      = DEF_V_SYNC,
    parameter int unsigned V_BP        = DEF_V_BP,
    parameter bit          HS_POL      = POL_ACTIVE_LOW,
    parameter bit          VS_POL      = POL_ACTIVE_LOW,
    parameter int unsigned PIX_W       = DEF_PIX_W,
    parameter int unsigned MEM_LAT     = 1,
    parameter int unsigned SCALE_SHIFT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    vga_timing_gen_if.master bus
);
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned XW      = clog2(H_TOTAL);
    localparam int unsigned YW      = clog2(V_TOTAL);

    if (MEM_LAT > 7 || (H_ACTIVE + H_FP + H_SYNC) >= (1 << XW) ||
        (V_ACTIVE + V_FP + V_SYNC) >= (1 << YW)) begin : g_badParams
        $error("vga_timing_gen: timing parameters do not fit the counter widths");
    end

    localparam logic [XW-1:0] X_LAST   = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] X_ACT    = XW'(H_ACTIVE);
    localparam logic [XW-1:0] X_HS_ON  = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] X_HS_OFF = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [YW-1:0] Y_LAST   = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] Y_ACT    = YW'(V_ACTIVE);
    localparam logic [YW-1:0] Y_VS_ON  = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] Y_VS_OFF = YW'(V_ACTIVE + V_FP + V_SYNC);

    logic [XW-1:0]    xCnt;
    logic [YW-1:0]    yCnt;
    logic             xZero;
    sync_t            syncPre;
    sync_t            syncDly;
    logic [PIX_W-1:0] pixNext;

    // Raster counters; the line counter steps only on the column wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            xCnt <= '0;
            yCnt <= '0;
        end else if (en) begin
            if (xCnt == X_LAST) begin
                xCnt <= '0;
                yCnt <= (yCnt == Y_LAST) ? '0 : yCnt + YW'(1);
            end else begin
                xCnt <= xCnt + XW'(1);
            end
        end
    end

    always_comb begin
        syncPre    = '0;
        syncPre.hs = (xCnt >= X_HS_ON) && (xCnt < X_HS_OFF);
        syncPre.vs = (yCnt >= Y_VS_ON) && (yCnt < Y_VS_OFF);
        syncPre.de = (xCnt < X_ACT) && (yCnt < Y_ACT);
    end

    // MEM_LAT stages here plus the output register give MEM_LAT+1 ticks in total.
    vga_timing_gen_delay_line #(
        .WIDTH ($bits(sync_t)),
        .DEPTH (MEM_LAT)
    ) u_syncDelay (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .din  (syncPre),
        .dout (syncDly)
    );

    assign pixNext = syncDly.de ? bus.pixelIn : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.pixelOut <= '0;
            bus.Hsync    <= ~HS_POL;
            bus.Vsync    <= ~VS_POL;
            bus.de       <= 1'b0;
        end else if (en) begin
            bus.pixelOut <= pixNext;
            bus.Hsync    <= syncDly.hs ~^ HS_POL;
            bus.Vsync    <= syncDly.vs ~^ VS_POL;
            bus.de       <= syncDly.de;
        end
    end

    assign xZero           = (xCnt == '0);
    assign bus.posX        = xCnt;
    assign bus.posY        = yCnt;
    assign bus.fbX         = xCnt >> SCALE_SHIFT;
    assign bus.fbY         = yCnt >> SCALE_SHIFT;
    assign bus.rd_en       = syncPre.de;
    assign bus.line_start  = xZero;
    assign bus.frame_start = xZero && (yCnt == '0);
endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: default 640x480 instance (MEM_LAT=1, SCALE_SHIFT=2) and a tiny 12x7 instance.
module tb_vga_timing_gen;
    import vga_timing_gen_pkg::*;

    localparam int unsigned XWA = clog2(800);
    localparam int unsigned YWA = clog2(525);
    localparam int unsigned XWB = clog2(12);
    localparam int unsigned YWB = clog2(7);
    localparam int NFIELD = 11;
    localparam int NSPOT  = 62;

    typedef struct {
        longint cyc;
        int     d;
        int     k;
        int     v;
    } chk_t;

    logic   clk = 1'b0;
    logic   rstA, rstB, enA, enB;
    longint cyc = 0;
    int     nChecks = 0;
    int     nErrors = 0;
    int     tA, tB;
    chk_t   q[$];
    logic [7:0] memB1 = '0;

    string fieldName[NFIELD] = '{"pixelOut", "Hsync", "Vsync", "de", "posX", "posY",
                                 "fbX", "fbY", "rd_en", "line_start", "frame_start"};

    // {dut, tick, field, hand-computed value}; tick -1 means held in reset.
    int spot[NSPOT][4] = '{
        '{0,-1,1,1}, '{0,-1,2,1}, '{0,-1,3,0}, '{0,-1,0,0}, '{0,-1,4,0},
        '{0,0,10,1}, '{0,1,3,0}, '{0,2,3,1}, '{0,2,0,0}, '{0,641,0,127}, '{0,641,3,1},
        '{0,642,3,0}, '{0,642,0,0},
        '{0,657,1,1}, '{0,658,1,0}, '{0,753,1,0}, '{0,754,1,1}, '{0,801,3,0}, '{0,802,3,1},
        '{0,3,6,0}, '{0,4,6,1}, '{0,639,6,159}, '{0,3199,7,0}, '{0,3200,7,1}, '{0,800,4,0},
        '{0,800,5,1}, '{0,800,9,1},
        '{0,4300,0,42}, '{0,4300,3,1}, '{0,4300,4,300},
        '{1,-1,1,0}, '{1,-1,2,0}, '{1,-1,3,0},
        '{1,11,1,0}, '{1,12,1,1}, '{1,13,1,1}, '{1,14,1,0}, '{1,62,2,0}, '{1,63,2,1},
        '{1,74,2,1}, '{1,75,2,0},
        '{1,2,3,0}, '{1,3,3,1}, '{1,3,0,0}, '{1,10,0,7}, '{1,11,3,0}, '{1,15,3,1},
        '{1,15,0,16}, '{1,51,3,0}, '{1,46,0,55},
        '{1,83,4,11}, '{1,83,5,6}, '{1,84,4,0}, '{1,84,5,0}, '{1,84,10,1}, '{1,6,6,3},
        '{1,24,7,1}, '{1,12,9,1}, '{1,12,5,1},
        '{1,7,8,1}, '{1,8,8,0}, '{1,43,8,1}
    };

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vga_timing_gen_if #(.PIX_W(8), .XW(XWA), .YW(YWA)) busA ();
    vga_timing_gen_if #(.PIX_W(8), .XW(XWB), .YW(YWB)) busB ();

    vga_timing_gen #(
        .MEM_LAT     (1),
        .SCALE_SHIFT (2)
    ) dutA (
        .clk (clk),
        .rst (rstA),
        .en  (enA),
        .bus (busA.master)
    );

    vga_timing_gen #(
        .H_ACTIVE (8), .H_FP (1), .H_SYNC (2), .H_BP (1),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .HS_POL (1'b1), .VS_POL (1'b1),
        .PIX_W (8), .MEM_LAT (2), .SCALE_SHIFT (1)
    ) dutB (
        .clk (clk),
        .rst (rstB),
        .en  (enB),
        .bus (busB.master)
    );

    // Framebuffer models: A returns posX[7:0] after 1 tick, B returns {0,y,x} after 2 ticks.
    always @(posedge clk) if (enA) busA.pixelIn <= busA.posX[7:0];
    always @(posedge clk) begin
        if (enB) begin
            memB1         <= {1'b0, busB.posY, busB.posX};
            busB.pixelIn  <= memB1;
        end
    end

    // Expected output after t ticks from reset release (t=-1: in reset).
    function automatic int model(input int d, input int t, input int k);
        int ha, hfp, hsw, ht, va, vfp, vsw, vt, hp, vp, lat, ss;
        int x, y, p, px, py;
        bit pv, hsA, vsA, deA;
        if (d == 0) begin
            ha = 640; hfp = 16; hsw = 96; ht = 800; va = 480; vfp = 10; vsw = 2; vt = 525;
            hp = 0; vp = 0; lat = 1; ss = 2;
        end else begin
            ha = 8; hfp = 1; hsw = 2; ht = 12; va = 4; vfp = 1; vsw = 1; vt = 7;
            hp = 1; vp = 1; lat = 2; ss = 1;
        end
        x  = (t <= 0) ? 0 : t % ht;
        y  = (t <= 0) ? 0 : (t / ht) % vt;
        p  = t - lat - 1;
        pv = (p >= 0);
        px = pv ? p % ht : 0;
        py = pv ? (p / ht) % vt : 0;
        hsA = pv && px >= ha + hfp && px < ha + hfp + hsw;
        vsA = pv && py >= va + vfp && py < va + vfp + vsw;
        deA = pv && px < ha && py < va;
        case (k)
            0:       return deA ? ((d == 0) ? px % 256 : py * 16 + px) : 0;
            1:       return hsA ? hp : 1 - hp;
            2:       return vsA ? vp : 1 - vp;
            3:       return int'(deA);
            4:       return x;
            5:       return y;
            6:       return x >> ss;
            7:       return y >> ss;
            8:       return int'(x < ha && y < va);
            9:       return int'(x == 0);
            10:      return int'(x == 0 && y == 0);
            default: return 0;
        endcase
    endfunction

    function automatic int dutVal(input int d, input int k);
        if (d == 0) begin
            case (k)
                0:       return int'(busA.pixelOut);
                1:       return int'(busA.Hsync);
                2:       return int'(busA.Vsync);
                3:       return int'(busA.de);
                4:       return int'(busA.posX);
                5:       return int'(busA.posY);
                6:       return int'(busA.fbX);
                7:       return int'(busA.fbY);
                8:       return int'(busA.rd_en);
                9:       return int'(busA.line_start);
                default: return int'(busA.frame_start);
            endcase
        end
        case (k)
            0:       return int'(busB.pixelOut);
            1:       return int'(busB.Hsync);
            2:       return int'(busB.Vsync);
            3:       return int'(busB.de);
            4:       return int'(busB.posX);
            5:       return int'(busB.posY);
            6:       return int'(busB.fbX);
            7:       return int'(busB.fbY);
            8:       return int'(busB.rd_en);
            9:       return int'(busB.line_start);
            default: return int'(busB.frame_start);
        endcase
    endfunction

    task automatic pushChk(input int d, input int k, input int v);
        chk_t c;
        c.cyc = cyc;
        c.d   = d;
        c.k   = k;
        c.v   = v;
        q.push_back(c);
    endtask

    task automatic pushAll(input int d, input int t);
        for (int k = 0; k < NFIELD; k++) pushChk(d, k, model(d, t, k));
        for (int i = 0; i < NSPOT; i++)
            if (spot[i][0] == d && spot[i][1] == t) pushChk(d, spot[i][2], spot[i][3]);
    endtask

    task automatic tick(input int d, input logic e, inout int t);
        if (d == 0) enA = e;
        else        enB = e;
        @(posedge clk);
        #1;
        if (e && t >= 0) t++;
        pushAll(d, t);
    endtask

    // Monitor: compares every expectation queued for the current cycle.
    always @(negedge clk) begin
        chk_t c;
        int   act;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            c = q.pop_front();
            nChecks++;
            if (c.cyc != cyc) begin
                nErrors++;
                $display("FAIL dut%0d %s: expectation for cycle %0d left unchecked until %0d",
                         c.d, fieldName[c.k], c.cyc, cyc);
            end else begin
                act = dutVal(c.d, c.k);
                if (act != c.v) begin
                    nErrors++;
                    $display("FAIL dut%0d %s cycle %0d: got %0d, expected %0d",
                             c.d, fieldName[c.k], cyc, act, c.v);
                end
            end
        end
    end

    initial begin
        rstA = 1'b0; rstB = 1'b0; enA = 1'b0; enB = 1'b0;
        tA = -1; tB = -1;
        repeat (3) begin
            @(posedge clk);
            #1;
            pushAll(0, -1);
            pushAll(1, -1);
        end
        rstA = 1'b1; tA = 0; pushAll(0, 0);

        // Continuous pixel ticks over four lines.
        while (tA < 3300) tick(0, 1'b1, tA);

        // Pixel tick on every second clock; outputs must hold on idle clocks.
        for (int i = 0; i < 1600; i++) tick(0, 1'(i % 2 == 0), tA);

        // Reset mid-line while active video is on the pins.
        while (tA % 800 != 300) tick(0, 1'b1, tA);
        enA = 1'b0;
        @(posedge clk);
        #1;
        rstA = 1'b0; tA = -1; pushAll(0, -1);
        repeat (2) tick(0, 1'b1, tA);
        rstA = 1'b1; tA = 0; pushAll(0, 0);
        repeat (6) tick(0, 1'b1, tA);
        enA = 1'b0;

        // Tiny mode: more than two whole frames with a short en=0 stall.
        rstB = 1'b1; tB = 0; pushAll(1, 0);
        while (tB < 100) tick(1, 1'b1, tB);
        repeat (3) tick(1, 1'b0, tB);
        while (tB < 190) tick(1, 1'b1, tB);
        enB = 1'b0;

        @(posedge clk);
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            nChecks++;
            nErrors++;
            $display("FAIL scoreboard drain: %0d entries left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end
endmodule
